// File: rtl/ssd_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment
// display driver. One conversion takes WIDTH shift cycles plus one load cycle;
// results and the leading-zero blank mask hold until the next conversion ends.
module ssd_bcd_converter #(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    // Every digit blank except the ones digit, which always shows.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  sh, sh_n;
    logic [BW-1:0]     bcd_s, bcd_n;
    logic              ovf_s, ovf_n;
    logic [CW-1:0]     cnt, cnt_n;

    logic              busy_n;
    logic              done_n;
    logic [BW-1:0]     bcd_out_n;
    logic [DIGITS-1:0] blank_n;
    logic              overflow_n;

    logic [BW-1:0]     bcd_adj;
    logic [DIGITS-1:0] blank_calc;
    logic              zero_run;

    // Add-3 correction on every scratch digit that is 5..9 before the shift.
    always_comb begin
        bcd_adj = bcd_s;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_s[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_s[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero mask: digit i blanks when it and all digits above are zero.
    always_comb begin
        blank_calc = '0;
        zero_run   = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_run      = zero_run & (bcd_s[4*i +: 4] == 4'd0);
            blank_calc[i] = zero_run;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        sh_n       = sh;
        bcd_n      = bcd_s;
        ovf_n      = ovf_s;
        cnt_n      = cnt;
        done_n     = 1'b0;
        bcd_out_n  = bcd_out;
        blank_n    = blank;
        overflow_n = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    sh_n    = bin_in;
                    bcd_n   = '0;
                    ovf_n   = 1'b0;
                    cnt_n   = CW'(WIDTH);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                bcd_n = {bcd_adj[BW-2:0], sh[WIDTH-1]};
                sh_n  = sh << 1;
                ovf_n = ovf_s | bcd_adj[BW-1];
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                bcd_out_n  = bcd_s;
                overflow_n = ovf_s;
                blank_n    = blank_calc;
                done_n     = 1'b1;
                state_n    = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State, datapath and registered outputs; reset aborts any conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            bcd_s    <= '0;
            ovf_s    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            blank    <= BLANK_RST;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            bcd_s    <= bcd_n;
            ovf_s    <= ovf_n;
            cnt      <= cnt_n;
            busy     <= busy_n;
            done     <= done_n;
            bcd_out  <= bcd_out_n;
            blank    <= blank_n;
            overflow <= overflow_n;
        end
    end

endmodule

// File: tb/tb_ssd_bcd_converter.sv
// Scoreboard bench for ssd_bcd_converter: a 4-digit and a 3-digit instance.
module tb_ssd_bcd_converter;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start4, start3;
    logic [12:0] bin4, bin3;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  blank4;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic [2:0]  blank3;

    exp_t q4[$];
    exp_t q3[$];
    int   total;
    int   bad;
    int   n_done4;
    int   n_done3;
    bit   stim_done;

    ssd_bcd_converter #(.WIDTH(13), .DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .blank(blank4), .overflow(ovf4)
    );

    ssd_bcd_converter #(.WIDTH(13), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin_in(bin3),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .blank(blank3), .overflow(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] b, input logic [3:0] bl, input logic o);
        exp_t e;
        e.bcd = b; e.blank = bl; e.ovf = o;
        return e;
    endfunction

    // Issue one start pulse, wait for done and check the WIDTH+1 latency.
    task automatic run_conv(input int which, input logic [12:0] val, input exp_t e, input string name);
        int k;
        bit seen;
        if (which == 4) q4.push_back(e); else q3.push_back(e);
        @(posedge clk); #2;
        if (which == 4) begin start4 = 1'b1; bin4 = val; end
        else            begin start3 = 1'b1; bin3 = val; end
        @(posedge clk); #1;
        start4 = 1'b0; start3 = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            @(posedge clk); k++; #1;
            seen = (which == 4) ? done4 : done3;
        end
        chk({name, " latency"}, k, 14);
        repeat (2) @(posedge clk);
    endtask

    // Compare one DUT result against the head of its queue.
    task automatic pop_check(input string name, input int which, input exp_t got);
        exp_t want;
        if (which == 4 ? q4.size() == 0 : q3.size() == 0) begin
            total++; bad++;
            $display("FAIL %s unexpected done got=%0h want=none", name, got.bcd);
        end else begin
            want = (which == 4) ? q4.pop_front() : q3.pop_front();
            chk({name, " bcd"},   32'(got.bcd),   32'(want.bcd));
            chk({name, " blank"}, 32'(got.blank), 32'(want.blank));
            chk({name, " ovf"},   32'(got.ovf),   32'(want.ovf));
        end
    endtask

    initial begin
        int k, gap, base;
        bit seen;
        rst = 1'b1; start4 = 1'b0; start3 = 1'b0; bin4 = '0; bin3 = '0;
        total = 0; bad = 0; n_done4 = 0; n_done3 = 0; stim_done = 0;
        fork
            // Monitor: pops expected results whenever either DUT pulses done.
            begin
                while (!stim_done) begin
                    @(negedge clk);
                    if (done4) begin n_done4++; pop_check("d4", 4, mk(bcd4, blank4, ovf4)); end
                    if (done3) begin n_done3++; pop_check("d3", 3, mk({4'h0, bcd3}, {1'b0, blank3}, ovf3)); end
                end
            end
            // Stimulus.
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("rst busy",  32'(busy4),  0);
                chk("rst done",  32'(done4),  0);
                chk("rst bcd",   32'(bcd4),   0);
                chk("rst blank", 32'(blank4), 32'b1110);
                chk("rst ovf",   32'(ovf4),   0);
                chk("rst blank3", 32'(blank3), 32'b110);
                rst = 1'b0;
                repeat (2) @(posedge clk);

                run_conv(4, 13'd0,    mk(16'h0000, 4'b1110, 1'b0), "zero");
                run_conv(4, 13'd8191, mk(16'h8191, 4'b0000, 1'b0), "max");
                run_conv(4, 13'd1234, mk(16'h1234, 4'b0000, 1'b0), "1234");
                run_conv(4, 13'd40,   mk(16'h0040, 4'b1100, 1'b0), "40");
                run_conv(3, 13'd1000, mk(16'h0000, 4'b0110, 1'b1), "ovf1000");
                run_conv(3, 13'd999,  mk(16'h0999, 4'b0000, 1'b0), "fit999");

                // start re-pulsed mid-conversion with a new value is ignored.
                q4.push_back(mk(16'h0005, 4'b1110, 1'b0));
                base = n_done4;
                @(posedge clk); #2; start4 = 1'b1; bin4 = 13'd5;
                @(posedge clk); #1; start4 = 1'b0;
                for (int c = 1; c <= 30; c++) begin
                    @(posedge clk); #1;
                    if (c == 2) chk("ign busy", 32'(busy4), 1);
                    if (c == 3 || c == 7) begin start4 = 1'b1; bin4 = 13'd77; end
                    else begin start4 = 1'b0; end
                end
                chk("ign done count", 32'(n_done4 - base), 1);

                // start held in the done cycle: next done WIDTH+2 cycles later.
                q4.push_back(mk(16'h4321, 4'b0000, 1'b0));
                q4.push_back(mk(16'h0077, 4'b1100, 1'b0));
                @(posedge clk); #2; start4 = 1'b1; bin4 = 13'd4321;
                @(posedge clk); #1; start4 = 1'b0;
                k = 0; seen = 0;
                while (!seen && k < 40) begin @(posedge clk); k++; #1; seen = done4; end
                chk("b2b first latency", k, 14);
                chk("b2b busy falls", 32'(busy4), 0);
                start4 = 1'b1; bin4 = 13'd77;
                gap = 0; seen = 0;
                @(posedge clk); gap++; #1; start4 = 1'b0;
                while (!seen && gap < 40) begin @(posedge clk); gap++; #1; seen = done4; end
                chk("b2b gap", gap, 15);
                repeat (2) @(posedge clk);

                // Asynchronous reset mid-conversion aborts without a done.
                base = n_done4;
                @(posedge clk); #2; start4 = 1'b1; bin4 = 13'd4321;
                @(posedge clk); #1; start4 = 1'b0;
                repeat (6) @(posedge clk);
                #3; rst = 1'b1; #1;
                chk("arst busy",  32'(busy4),  0);
                chk("arst bcd",   32'(bcd4),   0);
                chk("arst blank", 32'(blank4), 32'b1110);
                chk("arst ovf",   32'(ovf4),   0);
                chk("arst bcd3",  32'(bcd3),   0);
                @(posedge clk); #2; rst = 1'b0;
                repeat (20) @(posedge clk);
                chk("arst no done", 32'(n_done4 - base), 0);
                run_conv(4, 13'd4321, mk(16'h4321, 4'b0000, 1'b0), "after rst");

                repeat (3) @(posedge clk);
                chk("q4 drained", q4.size(), 0);
                chk("q3 drained", q3.size(), 0);
                stim_done = 1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
